// File: rtl/fir_pkg.sv
// fir_pkg: register map, status bit and state encoding shared by the FIR config sequencer.
// Build option FIR_SEQ_TIMEOUT_EN (used in fir_cfg_seq) bounds status polling.
package fir_pkg;
  localparam int REG_AP_CTRL  = 'h00;
  localparam int REG_DATA_LEN = 'h10;
  localparam int REG_TAP_BASE = 'h40;
  localparam int AP_DONE_BIT  = 1;
  typedef enum logic [2:0] {
    S_IDLE, S_WR_LEN, S_WR_TAP, S_WR_START, S_RD_AR, S_RD_R, S_DONE
  } state_e;
  function automatic int tap_addr(input int i);
    return REG_TAP_BASE + 4 * i;
  endfunction
endpackage

// File: rtl/fir_axil_wr.sv
// fir_axil_wr: single AXI-Lite write with independent AW/W handshakes; done_o when both have landed.
module fir_axil_wr
  import fir_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          awvalid_o,
  output logic [AW-1:0] awaddr_o,
  input  logic          awready_i,
  output logic          wvalid_o,
  output logic [DW-1:0] wdata_o,
  input  logic          wready_i,
  output logic          done_o
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid_o <= 1'b0;
      wvalid_o  <= 1'b0;
      awaddr_o  <= '0;
      wdata_o   <= '0;
    end else if (start_i) begin
      awvalid_o <= 1'b1;
      wvalid_o  <= 1'b1;
      awaddr_o  <= addr_i;
      wdata_o   <= data_i;
    end else begin
      if (awready_i) awvalid_o <= 1'b0;
      if (wready_i) wvalid_o <= 1'b0;
    end
  end
  // complete once every still-pending channel handshakes this cycle
  assign done_o = (awvalid_o || wvalid_o) && (!awvalid_o || awready_i) && (!wvalid_o || wready_i);
endmodule

// File: rtl/fir_cfg_seq.sv
// fir_cfg_seq: programs length, taps and ap_start over AXI-Lite, then polls ap_done.
// Define FIR_SEQ_TIMEOUT_EN to abort polling after POLL_TIMEOUT reads with err set.
module fir_cfg_seq
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH  = 12,
  parameter int pDATA_WIDTH  = 32,
  parameter int Tape_Num     = 11,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   tap_we,
  input  logic [3:0]             tap_idx,
  input  logic [pDATA_WIDTH-1:0] tap_wdata,
  input  logic                   cmd_valid,
  input  logic [pDATA_WIDTH-1:0] cmd_len,
  output logic                   cmd_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready
);
  localparam int IW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  state_e                 state_q;
  logic [IW-1:0]          idx_q;
  logic [pDATA_WIDTH-1:0] taps_q [Tape_Num];
  logic                   arvalid_q, rready_q, done_q;
  logic                   wr_start, wr_done, last_tap;
  logic [IW-1:0]          nxt_idx;
  logic [pADDR_WIDTH-1:0] wr_addr;
  logic [pDATA_WIDTH-1:0] wr_data;
  logic                   unused_ok;
`ifdef FIR_SEQ_TIMEOUT_EN
  logic                   err_q;
  logic [31:0]            poll_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign unused_ok = ^{rdata, 32'(POLL_TIMEOUT)};
  assign cmd_ready = state_q == S_IDLE;
  assign busy      = !cmd_ready;
  assign done      = done_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign araddr    = pADDR_WIDTH'(REG_AP_CTRL);
  assign last_tap  = idx_q == IW'(Tape_Num - 1);
  assign nxt_idx   = idx_q + 1'b1;
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n)
      for (int k = 0; k < Tape_Num; k++) taps_q[k] <= '0;
    else if (tap_we && int'(tap_idx) < Tape_Num)
      taps_q[IW'(tap_idx)] <= tap_wdata;
  end
  // the next write is launched in the same cycle the previous one completes
  always_comb begin
    wr_start = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    case (state_q)
      S_IDLE: begin
        wr_start = cmd_valid;
        wr_addr  = pADDR_WIDTH'(REG_DATA_LEN);
        wr_data  = cmd_len;
      end
      S_WR_LEN: begin
        wr_start = wr_done;
        wr_addr  = pADDR_WIDTH'(REG_TAP_BASE);
        wr_data  = taps_q[0];
      end
      S_WR_TAP: begin
        wr_start = wr_done;
        wr_addr  = last_tap ? pADDR_WIDTH'(REG_AP_CTRL) : pADDR_WIDTH'(tap_addr(int'(nxt_idx)));
        wr_data  = last_tap ? pDATA_WIDTH'(1) : taps_q[nxt_idx];
      end
      default: ;
    endcase
  end
  fir_axil_wr #(.AW(pADDR_WIDTH), .DW(pDATA_WIDTH)) u_wr (
    .clk(axis_clk), .rst_n(axis_rst_n), .start_i(wr_start), .addr_i(wr_addr), .data_i(wr_data),
    .awvalid_o(awvalid), .awaddr_o(awaddr), .awready_i(awready),
    .wvalid_o(wvalid), .wdata_o(wdata), .wready_i(wready), .done_o(wr_done)
  );
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIR_SEQ_TIMEOUT_EN
      err_q     <= 1'b0;
      poll_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          state_q <= S_WR_LEN;
          idx_q   <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
          err_q   <= 1'b0;
          poll_q  <= '0;
`endif
        end
        S_WR_LEN: if (wr_done) state_q <= S_WR_TAP;
        S_WR_TAP: if (wr_done) begin
          if (last_tap) state_q <= S_WR_START;
          else idx_q <= nxt_idx;
        end
        S_WR_START: if (wr_done) begin
          state_q   <= S_RD_AR;
          arvalid_q <= 1'b1;
        end
        S_RD_AR: if (arready) begin
          state_q   <= S_RD_R;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
        end
        S_RD_R: if (rvalid) begin
          rready_q <= 1'b0;
`ifdef FIR_SEQ_TIMEOUT_EN
          poll_q   <= poll_q + 1'b1;
`endif
          if (rdata[AP_DONE_BIT]) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
`ifdef FIR_SEQ_TIMEOUT_EN
          else if (poll_q >= 32'(POLL_TIMEOUT - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
`endif
          else begin
            state_q   <= S_RD_AR;
            arvalid_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_cfg_seq.sv
// tb_fir_cfg_seq: directed checks of the FIR config sequencer against a small AXI-Lite slave model.
module tb_fir_cfg_seq;
  localparam int NT = 11;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        tap_we = 1'b0, cmd_valid = 1'b0;
  logic [3:0]  tap_idx = '0;
  logic [31:0] tap_wdata = '0, cmd_len = '0;
  logic        cmd_ready, busy, done, err, awvalid, wvalid, arvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;
  int total = 0, bad = 0;
  int aw_dly = 0, w_dly = 0, busy_polls = 0, aw_cnt = 0, w_cnt = 0;
  int reads = 0, ar_cnt = 0, done_cnt = 0;
  bit r_pend = 1'b0;
  logic [11:0] aw_log[$];
  logic [31:0] w_log[$];

  fir_cfg_seq #(.POLL_TIMEOUT(4)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .tap_we(tap_we), .tap_idx(tap_idx), .tap_wdata(tap_wdata),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready), .busy(busy), .done(done), .err(err),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready), .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready), .rvalid(rvalid), .rdata(rdata), .rready(rready)
  );

  always #5 clk = ~clk;

  // slave model: readies set on the falling edge; a handshake seen here lands on the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0;
      r_pend = 1'b0; aw_cnt = 0; w_cnt = 0;
    end else begin
      awready = awvalid && aw_cnt >= aw_dly;
      wready  = wvalid && w_cnt >= w_dly;
      aw_cnt  = (!awvalid || awready) ? 0 : aw_cnt + 1;
      w_cnt   = (!wvalid || wready) ? 0 : w_cnt + 1;
      if (awvalid && awready) aw_log.push_back(awaddr);
      if (wvalid && wready) w_log.push_back(wdata);
      arready = arvalid;
      rvalid  = r_pend;
      rdata   = (reads < busy_polls) ? 32'h4 : 32'h6;
      if (rvalid && rready) begin reads++; r_pend = 1'b0; end
      if (arvalid && arready) begin ar_cnt++; r_pend = 1'b1; end
    end
    done_cnt += int'(done);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_taps();
    for (int i = 0; i < NT; i++) begin
      @(negedge clk); tap_we = 1'b1; tap_idx = 4'(i); tap_wdata = 32'(i + 1);
    end
    @(negedge clk); tap_idx = 4'd11; tap_wdata = 32'hdead;
    @(negedge clk); tap_we = 1'b0;
  endtask

  task automatic start_cmd(input logic [31:0] len);
    @(negedge clk); cmd_valid = 1'b1; cmd_len = len;
    @(negedge clk); cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk); seen = done;
    end
    chk(tag, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_log(input int base, input logic [31:0] len);
    logic [11:0] ea;
    logic [31:0] ed;
    for (int k = 0; k < 13; k++) begin
      ea = (k == 0) ? 12'h010 : (k == 12) ? 12'h000 : 12'(32'h40 + 4 * (k - 1));
      ed = (k == 0) ? len : (k == 12) ? 32'd1 : 32'(k);
      chk($sformatf("awaddr[%0d]", base + k), 32'(aw_log[base + k]), 32'(ea));
      chk($sformatf("wdata[%0d]", base + k), w_log[base + k], ed);
    end
  endtask

  initial begin
    int b;
    bit seen;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_taps();
    // basic run, zero-latency slave, done on first poll
    b = aw_log.size(); reads = 0; ar_cnt = 0; done_cnt = 0;
    start_cmd(32'd64);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cmd_ready", 32'(cmd_ready), 32'd0);
    wait_done("t1_done_seen");
    chk("t1_nwr", 32'(aw_log.size() - b), 32'd13);
    chk("t1_nw", 32'(w_log.size() - b), 32'd13);
    chk_log(b, 32'd64);
    chk("t1_reads", 32'(reads), 32'd1);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    // awready delayed 3 cycles, wready immediate
    aw_dly = 3; b = aw_log.size(); done_cnt = 0;
    start_cmd(32'h20);
    @(negedge clk);
    chk("t2_wvalid_dropped", 32'(wvalid), 32'd0);
    chk("t2_awvalid_held", 32'(awvalid), 32'd1);
    chk("t2_awaddr_held", 32'(awaddr), 32'h010);
    wait_done("t2_done_seen");
    chk("t2_nwr", 32'(aw_log.size() - b), 32'd13);
    chk("t2_nw", 32'(w_log.size() - b), 32'd13);
    chk_log(b, 32'h20);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    aw_dly = 0;
    // five busy polls then ap_done
    busy_polls = 5; reads = 0; ar_cnt = 0; done_cnt = 0;
    start_cmd(32'd100);
    wait_done("t3_done_seen");
    chk("t3_reads", 32'(reads), 32'd6);
    chk("t3_ars", 32'(ar_cnt), 32'd6);
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);
    chk("t3_err", 32'(err), 32'd0);
`ifdef FIR_SEQ_TIMEOUT_EN
    busy_polls = 1000000; reads = 0; done_cnt = 0;
    start_cmd(32'd7);
    wait_done("t4_done_seen");
    chk("t4_reads", 32'(reads), 32'd4);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);
    busy_polls = 0;
    start_cmd(32'd7);
    chk("t4_err_cleared", 32'(err), 32'd0);
    wait_done("t4b_done_seen");
    chk("t4b_err", 32'(err), 32'd0);
`else
    busy_polls = 9; reads = 0; done_cnt = 0;
    start_cmd(32'd7);
    wait_done("t4_done_seen");
    chk("t4_reads", 32'(reads), 32'd10);
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);
`endif
    // reset while tap 5 is being written
    busy_polls = 0;
    start_cmd(32'd64);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (awvalid && awaddr == 12'h054) seen = 1'b1;
      else @(negedge clk);
    end
    chk("t5_reached_tap5", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_awvalid", 32'(awvalid), 32'd0);
    chk("t5_wvalid", 32'(wvalid), 32'd0);
    chk("t5_arvalid", 32'(arvalid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    b = aw_log.size();
    repeat (3) @(negedge clk);
    chk("t5_no_more_wr", 32'(aw_log.size()), 32'(b));
    rst_n = 1'b1;
    load_taps();
    b = aw_log.size();
    start_cmd(32'd64);
    wait_done("t5_done_seen");
    chk("t5_nwr", 32'(aw_log.size() - b), 32'd13);
    chk_log(b, 32'd64);
    // cmd_valid held high across a whole run
    b = aw_log.size(); done_cnt = 0;
    @(negedge clk); cmd_valid = 1'b1; cmd_len = 32'd8;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk); seen = done;
    end
    chk("t6_first_done", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); seen = busy;
    end
    cmd_valid = 1'b0;
    chk("t6_second_accept", 32'(seen), 32'd1);
    wait_done("t6_second_done");
    chk("t6_nwr", 32'(aw_log.size() - b), 32'd26);
    chk_log(b, 32'd8);
    chk_log(b + 13, 32'd8);
    chk("t6_done_cnt", 32'(done_cnt), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
